// File: rtl/soc_system_dpram_avmm.sv
// soc_system_dpram_avmm: true dual-port RAM behind two Avalon-MM slaves (s1, s2) on one clock, with a clear engine.
// Latency: readdatavalid READ_LATENCY (1 or 2) cycles after an accepted read; a write is visible from the next cycle.
// Backpressure: waitrequest/waitrequest2 rise only while the clear engine runs; otherwise one command per port per cycle.
// Ports:
//   clk, reset (synchronous, active-high)
//   s1: address, read, write, byteenable, writedata -> readdata, readdatavalid, waitrequest
//   s2: address2, read2, write2, byteenable2, writedata2 -> readdata2, readdatavalid2, waitrequest2
//   clear_req (pulse) -> clear_busy; collision_count = saturating count of s2 writes dropped on collision
module soc_system_dpram_avmm #(
  parameter int                DATA_W       = 128,
  parameter int                ADDR_W       = 6,
  parameter int                READ_LATENCY = 1,
  parameter int                CLEAR_ON_RST = 1,
  parameter logic [DATA_W-1:0] CLEAR_VALUE  = '0,
  parameter int                CNT_W        = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   address,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0]   writedata,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  input  logic [ADDR_W-1:0]   address2,
  input  logic                read2,
  input  logic                write2,
  input  logic [DATA_W/8-1:0] byteenable2,
  input  logic [DATA_W-1:0]   writedata2,
  output logic [DATA_W-1:0]   readdata2,
  output logic                readdatavalid2,
  output logic                waitrequest2,
  input  logic                clear_req,
  output logic                clear_busy,
  output logic [CNT_W-1:0]    collision_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int BE_W  = DATA_W / 8;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              clr_pend_q, clr_pend_d;
  logic [CNT_W-1:0]  coll_cnt_q, coll_cnt_d;

  // Read pipeline, index 0 = s1, 1 = s2. Stage 1 captures the RAM word at
  // acceptance; stage 2 only matters when READ_LATENCY == 2.
  logic [1:0]        vld1_q, vld1_d, vld2_q, vld2_d;
  logic [DATA_W-1:0] dat1_q [2];
  logic [DATA_W-1:0] dat1_d [2];
  logic [DATA_W-1:0] dat2_q [2];
  logic [DATA_W-1:0] dat2_d [2];

  // RAM array; contents are deliberately not reset.
  logic [DATA_W-1:0] mem [DEPTH];

  logic       stall, clr_we, wr1_acc, wr2_acc, collide, wr2_keep;
  logic [1:0] rd_acc;

  always_comb begin
    stall     = (state_q == CLEAR) | reset;
    clr_we    = (state_q == CLEAR) & ~reset;
    wr1_acc   = write & ~stall;
    wr2_acc   = write2 & ~stall;
    // write wins over a simultaneous read on the same port
    rd_acc[0] = read & ~write & ~stall;
    rd_acc[1] = read2 & ~write2 & ~stall;
    // s1 wins the whole word on a same-address write, whatever the byte lanes
    collide   = wr1_acc & wr2_acc & (address == address2);
    wr2_keep  = wr2_acc & ~collide;
  end

  // Clear engine: one word per cycle, DEPTH cycles, not restartable while running.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_pend_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_pend_q | clear_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end
      end
      CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_W'(1);
        if (&clr_addr_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    coll_cnt_d = coll_cnt_q;
    if (collide && (coll_cnt_q != {CNT_W{1'b1}})) coll_cnt_d = coll_cnt_q + CNT_W'(1);
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      vld1_d[p] = rd_acc[p];
      dat1_d[p] = dat1_q[p];
      vld2_d[p] = vld1_q[p];
      dat2_d[p] = vld1_q[p] ? dat1_q[p] : dat2_q[p];
    end
    // Sampled before this cycle's writes land, so read-during-write returns old data.
    if (rd_acc[0]) dat1_d[0] = mem[address];
    if (rd_acc[1]) dat1_d[1] = mem[address2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      clr_addr_q <= '0;
      clr_pend_q <= (CLEAR_ON_RST != 0);
      coll_cnt_q <= '0;
      vld1_q     <= '0;
      vld2_q     <= '0;
      dat1_q[0]  <= '0;
      dat1_q[1]  <= '0;
      dat2_q[0]  <= '0;
      dat2_q[1]  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      clr_pend_q <= clr_pend_d;
      coll_cnt_q <= coll_cnt_d;
      vld1_q     <= vld1_d;
      vld2_q     <= vld2_d;
      dat1_q[0]  <= dat1_d[0];
      dat1_q[1]  <= dat1_d[1];
      dat2_q[0]  <= dat2_d[0];
      dat2_q[1]  <= dat2_d[1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr_q] <= CLEAR_VALUE;
    end else begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr1_acc && byteenable[b])   mem[address][b*8 +: 8]  <= writedata[b*8 +: 8];
        if (wr2_keep && byteenable2[b]) mem[address2][b*8 +: 8] <= writedata2[b*8 +: 8];
      end
    end
  end

  assign clear_busy      = clr_we;
  assign waitrequest     = clr_we;
  assign waitrequest2    = clr_we;
  assign collision_count = coll_cnt_q;
  assign readdata        = (READ_LATENCY == 2) ? dat2_q[0] : dat1_q[0];
  assign readdatavalid   = (READ_LATENCY == 2) ? vld2_q[0] : vld1_q[0];
  assign readdata2       = (READ_LATENCY == 2) ? dat2_q[1] : dat1_q[1];
  assign readdatavalid2  = (READ_LATENCY == 2) ? vld2_q[1] : vld1_q[1];

endmodule
